// File: rtl/ddr_timing_pkg.sv
// Shared command/violation encodings and the command-pin decoder for the DDR timing checker.
package ddr_timing_pkg;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACT,
    CMD_PRE,
    CMD_RD,
    CMD_WR,
    CMD_REF
  } cmd_e;

  typedef enum logic {
    BANK_CLOSED,
    BANK_OPEN
  } bank_state_e;

  // Bit positions in viol_vec; also the value reported as first_code.
  typedef enum logic [3:0] {
    V_TRC  = 4'd0,
    V_TRAS = 4'd1,
    V_TRP  = 4'd2,
    V_TRCD = 4'd3,
    V_TRRD = 4'd4,
    V_TFAW = 4'd5,
    V_TWR  = 4'd6,
    V_TRTP = 4'd7,
    V_TWTR = 4'd8,
    V_TRFC = 4'd9,
    V_PROT = 4'd10
  } viol_e;

  localparam int NUM_VIOL = 11;

  function automatic cmd_e ddr_decode(input logic valid, input logic cs_n,
                                      input logic ras_n, input logic cas_n,
                                      input logic we_n);
    cmd_e c;
    c = CMD_NOP;
    if (valid && !cs_n) begin
      case ({ras_n, cas_n, we_n})
        3'b011:  c = CMD_ACT;
        3'b010:  c = CMD_PRE;
        3'b101:  c = CMD_RD;
        3'b100:  c = CMD_WR;
        3'b001:  c = CMD_REF;
        default: c = CMD_NOP;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// One bank's CLOSED/OPEN state plus saturating cycles-since-ACT/PRE/RD/WR counters.
// Counters read 1 the cycle after their event and hold at all-ones once saturated.
module ddr_bank_tracker
#(
  parameter int CNT_W = 8
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act_i,
  input  logic             pre_i,
  input  logic             rd_i,
  input  logic             wr_i,
  input  logic             auto_pre_i,
  output logic             open_o,
  output logic [CNT_W-1:0] act_cnt_o,
  output logic [CNT_W-1:0] pre_cnt_o,
  output logic [CNT_W-1:0] rd_cnt_o,
  output logic [CNT_W-1:0] wr_cnt_o
);
  import ddr_timing_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bank_state_e      state_q, state_d;
  logic [CNT_W-1:0] act_cnt_q, pre_cnt_q, rd_cnt_q, wr_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    state_d = state_q;
    if (pre_i || auto_pre_i) begin
      state_d = BANK_CLOSED;
    end else if (act_i) begin
      state_d = BANK_OPEN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= BANK_CLOSED;
      act_cnt_q <= CNT_MAX;
      pre_cnt_q <= CNT_MAX;
      rd_cnt_q  <= CNT_MAX;
      wr_cnt_q  <= CNT_MAX;
    end else begin
      state_q   <= state_d;
      act_cnt_q <= act_i ? CNT_ONE : sat_inc(act_cnt_q);
      pre_cnt_q <= pre_i ? CNT_ONE : sat_inc(pre_cnt_q);
      rd_cnt_q  <= rd_i  ? CNT_ONE : sat_inc(rd_cnt_q);
      wr_cnt_q  <= wr_i  ? CNT_ONE : sat_inc(wr_cnt_q);
    end
  end

  assign open_o    = (state_q == BANK_OPEN);
  assign act_cnt_o = act_cnt_q;
  assign pre_cnt_o = pre_cnt_q;
  assign rd_cnt_o  = rd_cnt_q;
  assign wr_cnt_o  = wr_cnt_q;

endmodule

// File: rtl/ddr_timing_checker_cyc.sv
// Cycle-counting DDR timing/protocol checker: a command in cycle N is reported in cycle N+1
// via a pulse, sticky flags, a first-violation record and a saturating violation count.
module ddr_timing_checker_cyc
#(
  parameter int NUM_BANKS = 8,
  parameter int BA_W      = $clog2(NUM_BANKS),
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 8,
  parameter int T_RC      = 12,
  parameter int T_RAS     = 9,
  parameter int T_RP      = 3,
  parameter int T_RCD     = 3,
  parameter int T_RRD     = 2,
  parameter int T_FAW     = 10,
  parameter int T_WR      = 3,
  parameter int T_RTP     = 2,
  parameter int T_WTR     = 2,
  parameter int T_RFC     = 26
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cs_n,
  input  logic              ras_n,
  input  logic              cas_n,
  input  logic              we_n,
  input  logic [BA_W-1:0]   ba,
  input  logic [ADDR_W-1:0] addr,
  input  logic              clear,
  output logic              violation,
  output logic [10:0]       viol_vec,
  output logic [3:0]        first_code,
  output logic [BA_W-1:0]   first_bank,
  output logic              first_vld,
  output logic [15:0]       viol_count
);
  import ddr_timing_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cmd_e cmd;
  logic is_act, is_pre, is_rd, is_wr, is_ref, pre_all;
  logic unused_addr;

  logic [NUM_BANKS-1:0] bank_open;
  logic [CNT_W-1:0]     act_cnt [NUM_BANKS];
  logic [CNT_W-1:0]     pre_cnt [NUM_BANKS];
  logic [CNT_W-1:0]     rd_cnt  [NUM_BANKS];
  logic [CNT_W-1:0]     wr_cnt  [NUM_BANKS];

  logic [CNT_W-1:0] gact_cnt_q, gwr_cnt_q, ref_cnt_q;
  logic [CNT_W-1:0] faw_q [4];
  logic [1:0]       faw_ptr_q;

  logic [NUM_BANKS-1:0] ras_fail, wr_fail, rtp_fail, bank_mask;
  logic [NUM_VIOL-1:0]  viol_d;
  logic [3:0]           code_d;
  logic [BA_W-1:0]      bank_d;
  logic                 any_viol;

  logic                violation_q, first_vld_q;
  logic [NUM_VIOL-1:0] viol_vec_q;
  logic [3:0]          first_code_q;
  logic [BA_W-1:0]     first_bank_q;
  logic [15:0]         viol_count_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  assign cmd         = ddr_decode(cmd_valid, cs_n, ras_n, cas_n, we_n);
  assign is_act      = (cmd == CMD_ACT);
  assign is_pre      = (cmd == CMD_PRE);
  assign is_rd       = (cmd == CMD_RD);
  assign is_wr       = (cmd == CMD_WR);
  assign is_ref      = (cmd == CMD_REF);
  assign pre_all     = is_pre && addr[10];
  assign unused_addr = ^addr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel = (ba == BA_W'(b));

    ddr_bank_tracker #(.CNT_W(CNT_W)) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .act_i      (is_act && sel),
      .pre_i      (is_pre && (pre_all || sel)),
      .rd_i       (is_rd && sel),
      .wr_i       (is_wr && sel),
      .auto_pre_i ((is_rd || is_wr) && sel && addr[10]),
      .open_o     (bank_open[b]),
      .act_cnt_o  (act_cnt[b]),
      .pre_cnt_o  (pre_cnt[b]),
      .rd_cnt_o   (rd_cnt[b]),
      .wr_cnt_o   (wr_cnt[b])
    );
  end

  // A single PRE is checked on its own bank; PRE-all only on banks that are actually open.
  always_comb begin
    ras_fail = '0;
    wr_fail  = '0;
    rtp_fail = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (is_pre && (pre_all ? bank_open[b] : (ba == BA_W'(b)))) begin
        ras_fail[b] = (act_cnt[b] < CNT_W'(T_RAS));
        wr_fail[b]  = (wr_cnt[b]  < CNT_W'(T_WR));
        rtp_fail[b] = (rd_cnt[b]  < CNT_W'(T_RTP));
      end
    end
  end

  always_comb begin
    viol_d         = '0;
    viol_d[V_TRC]  = is_act && (act_cnt[ba] < CNT_W'(T_RC));
    viol_d[V_TRAS] = |ras_fail;
    viol_d[V_TRP]  = is_act && (pre_cnt[ba] < CNT_W'(T_RP));
    viol_d[V_TRCD] = (is_rd || is_wr) && (act_cnt[ba] < CNT_W'(T_RCD));
    viol_d[V_TRRD] = is_act && (gact_cnt_q < CNT_W'(T_RRD));
    viol_d[V_TFAW] = is_act && (faw_q[faw_ptr_q] < CNT_W'(T_FAW));
    viol_d[V_TWR]  = |wr_fail;
    viol_d[V_TRTP] = |rtp_fail;
    viol_d[V_TWTR] = is_rd && (gwr_cnt_q < CNT_W'(T_WTR));
    viol_d[V_TRFC] = (cmd != CMD_NOP) && (ref_cnt_q < CNT_W'(T_RFC));
    viol_d[V_PROT] = (is_act && bank_open[ba]) ||
                     ((is_rd || is_wr) && !bank_open[ba]) ||
                     (is_ref && (|bank_open));
  end

  assign any_viol = |viol_d;

  // The reported bank follows the check that won first_code, so PRE-all names a bank that failed it.
  always_comb begin
    code_d = '0;
    for (int i = NUM_VIOL - 1; i >= 0; i--) begin
      if (viol_d[i]) code_d = 4'(i);
    end
    bank_mask = '0;
    if (code_d == V_TRAS)      bank_mask = ras_fail;
    else if (code_d == V_TWR)  bank_mask = wr_fail;
    else if (code_d == V_TRTP) bank_mask = rtp_fail;
    bank_d = ba;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (bank_mask[b]) bank_d = BA_W'(b);
    end
  end

  // Slot at faw_ptr_q always holds the age of the 4th-previous ACT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gact_cnt_q <= CNT_MAX;
      gwr_cnt_q  <= CNT_MAX;
      ref_cnt_q  <= CNT_MAX;
      faw_ptr_q  <= '0;
      for (int i = 0; i < 4; i++) faw_q[i] <= CNT_MAX;
    end else begin
      gact_cnt_q <= is_act ? CNT_ONE : sat_inc(gact_cnt_q);
      gwr_cnt_q  <= is_wr  ? CNT_ONE : sat_inc(gwr_cnt_q);
      ref_cnt_q  <= is_ref ? CNT_ONE : sat_inc(ref_cnt_q);
      for (int i = 0; i < 4; i++) begin
        faw_q[i] <= (is_act && (faw_ptr_q == 2'(i))) ? CNT_ONE : sat_inc(faw_q[i]);
      end
      if (is_act) faw_ptr_q <= faw_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      violation_q  <= 1'b0;
      viol_vec_q   <= '0;
      first_code_q <= '0;
      first_bank_q <= '0;
      first_vld_q  <= 1'b0;
      viol_count_q <= '0;
    end else begin
      violation_q <= any_viol;
      if (clear) begin
        viol_vec_q   <= '0;
        first_code_q <= '0;
        first_bank_q <= '0;
        first_vld_q  <= 1'b0;
        viol_count_q <= '0;
      end else if (any_viol) begin
        viol_vec_q <= viol_vec_q | viol_d;
        if (!first_vld_q) begin
          first_vld_q  <= 1'b1;
          first_code_q <= code_d;
          first_bank_q <= bank_d;
        end
        if (viol_count_q != 16'hFFFF) viol_count_q <= viol_count_q + 16'd1;
      end
    end
  end

  assign violation  = violation_q;
  assign viol_vec   = viol_vec_q;
  assign first_code = first_code_q;
  assign first_bank = first_bank_q;
  assign first_vld  = first_vld_q;
  assign viol_count = viol_count_q;

endmodule

// File: tb/tb_ddr_timing_checker_cyc.sv
// Directed bench for ddr_timing_checker_cyc with default timing parameters and hand-derived expectations.
module tb_ddr_timing_checker_cyc;

  localparam int BA_W = 3;
  localparam logic [2:0] P_ACT = 3'b011;
  localparam logic [2:0] P_PRE = 3'b010;
  localparam logic [2:0] P_RD  = 3'b101;
  localparam logic [2:0] P_WR  = 3'b100;
  localparam logic [2:0] P_REF = 3'b001;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid;
  logic            cs_n, ras_n, cas_n, we_n;
  logic [BA_W-1:0] ba;
  logic [12:0]     addr;
  logic            clear;
  logic            violation;
  logic [10:0]     viol_vec;
  logic [3:0]      first_code;
  logic [BA_W-1:0] first_bank;
  logic            first_vld;
  logic [15:0]     viol_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ddr_timing_checker_cyc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cs_n       (cs_n),
    .ras_n      (ras_n),
    .cas_n      (cas_n),
    .we_n       (we_n),
    .ba         (ba),
    .addr       (addr),
    .clear      (clear),
    .violation  (violation),
    .viol_vec   (viol_vec),
    .first_code (first_code),
    .first_bank (first_bank),
    .first_vld  (first_vld),
    .viol_count (viol_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [10:0] vec,
                            input logic [3:0] code, input logic [BA_W-1:0] bank,
                            input logic vld, input logic [15:0] cnt);
    check({tag, ".violation"}, 32'(violation), 32'(v));
    check({tag, ".viol_vec"}, 32'(viol_vec), 32'(vec));
    check({tag, ".first_code"}, 32'(first_code), 32'(code));
    check({tag, ".first_bank"}, 32'(first_bank), 32'(bank));
    check({tag, ".first_vld"}, 32'(first_vld), 32'(vld));
    check({tag, ".viol_count"}, 32'(viol_count), 32'(cnt));
  endtask

  task automatic bus_idle();
    cmd_valid = 1'b0;
    cs_n      = 1'b1;
    {ras_n, cas_n, we_n} = 3'b111;
    ba        = '0;
    addr      = '0;
    clear     = 1'b0;
  endtask

  // One command cycle; returns #1 after the edge so outputs for that command are visible.
  task automatic drive(input logic [2:0] pins, input int bank, input logic a10);
    cmd_valid = 1'b1;
    cs_n      = 1'b0;
    {ras_n, cas_n, we_n} = pins;
    ba        = BA_W'(bank);
    addr      = '0;
    addr[10]  = a10;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_idle();
    do_reset();
    expect_out("reset", 1'b0, 11'h000, 4'd0, 3'd0, 1'b0, 16'd0);

    // tRCD: RD two cycles after ACT
    drive(P_ACT, 0, 1'b0);
    check("trcd.act_clean", 32'(violation), 32'd0);
    idle(1);
    drive(P_RD, 0, 1'b0);
    expect_out("trcd", 1'b1, 11'h008, 4'd3, 3'd0, 1'b1, 16'd1);
    idle(1);
    check("trcd.pulse_drop", 32'(violation), 32'd0);
    check("trcd.sticky", 32'(viol_vec), 32'h008);

    // tFAW pass: 5th ACT 11 cycles after the 1st
    do_reset();
    drive(P_ACT, 1, 1'b0); idle(2);
    drive(P_ACT, 2, 1'b0); idle(2);
    drive(P_ACT, 3, 1'b0); idle(2);
    drive(P_ACT, 4, 1'b0);
    check("faw_ok.4th", 32'(violation), 32'd0);
    idle(1);
    drive(P_ACT, 5, 1'b0);
    expect_out("faw_ok.5th", 1'b0, 11'h000, 4'd0, 3'd0, 1'b0, 16'd0);

    // tFAW fail: 5th ACT 8 cycles after the 1st
    do_reset();
    drive(P_ACT, 0, 1'b0); idle(1);
    drive(P_ACT, 1, 1'b0); idle(1);
    drive(P_ACT, 2, 1'b0); idle(1);
    drive(P_ACT, 3, 1'b0); idle(1);
    check("faw_fail.pre", 32'(viol_count), 32'd0);
    drive(P_ACT, 4, 1'b0);
    expect_out("faw_fail", 1'b1, 11'h020, 4'd5, 3'd4, 1'b1, 16'd1);

    // tRC + protocol in the same cycle
    do_reset();
    drive(P_ACT, 0, 1'b0);
    idle(4);
    drive(P_ACT, 0, 1'b0);
    expect_out("trc_prot", 1'b1, 11'h401, 4'd0, 3'd0, 1'b1, 16'd1);

    // PRE-all too early on two open banks, then RD to a now-closed bank
    do_reset();
    drive(P_ACT, 0, 1'b0); idle(1);
    drive(P_ACT, 1, 1'b0); idle(2);
    drive(P_PRE, 3, 1'b1);
    expect_out("preall_tras", 1'b1, 11'h002, 4'd1, 3'd0, 1'b1, 16'd1);
    idle(14);
    drive(P_RD, 1, 1'b0);
    expect_out("rd_closed", 1'b1, 11'h402, 4'd1, 3'd0, 1'b1, 16'd2);

    // tWTR, then a single PRE failing tRAS/tWR/tRTP together
    do_reset();
    drive(P_ACT, 0, 1'b0); idle(3);
    drive(P_WR, 0, 1'b0);
    check("wr_clean", 32'(violation), 32'd0);
    drive(P_RD, 0, 1'b0);
    expect_out("twtr", 1'b1, 11'h100, 4'd8, 3'd0, 1'b1, 16'd1);
    drive(P_PRE, 0, 1'b0);
    expect_out("pre_multi", 1'b1, 11'h1C2, 4'd8, 3'd0, 1'b1, 16'd2);

    // Auto-precharge closes the bank
    do_reset();
    drive(P_ACT, 2, 1'b0); idle(3);
    drive(P_RD, 2, 1'b1);
    check("rda_clean", 32'(violation), 32'd0);
    idle(20);
    drive(P_RD, 2, 1'b0);
    expect_out("rda_closed", 1'b1, 11'h400, 4'd10, 3'd2, 1'b1, 16'd1);

    // tRFC, then clear colliding with a new violation
    do_reset();
    drive(P_REF, 0, 1'b0);
    check("ref_clean", 32'(violation), 32'd0);
    idle(9);
    drive(P_ACT, 0, 1'b0);
    expect_out("trfc", 1'b1, 11'h200, 4'd9, 3'd0, 1'b1, 16'd1);
    idle(9);
    clear = 1'b1;
    drive(P_ACT, 1, 1'b0);
    expect_out("clear_wins", 1'b1, 11'h000, 4'd0, 3'd0, 1'b0, 16'd0);
    idle(1);
    drive(P_ACT, 2, 1'b0);
    expect_out("after_clear", 1'b1, 11'h200, 4'd9, 3'd2, 1'b1, 16'd1);

    // Reset mid-sequence discards history; long gaps saturate rather than wrap
    do_reset();
    drive(P_ACT, 0, 1'b0);
    do_reset();
    drive(P_ACT, 0, 1'b0);
    expect_out("post_reset_act", 1'b0, 11'h000, 4'd0, 3'd0, 1'b0, 16'd0);
    idle(19);
    drive(P_PRE, 0, 1'b0);
    check("sat.pre", 32'(violation), 32'd0);
    idle(240);
    drive(P_ACT, 0, 1'b0);
    expect_out("sat.act", 1'b0, 11'h000, 4'd0, 3'd0, 1'b0, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
